rf_wb_arbiter: RTL and testbench

Write-port arbiter and sequencer for the 32x32 register file, which has one write port (RegWrite/WA1/WD) and writes on posedge clk, ignoring register 0. Two producers share that port: the main pipeline writeback (port A) and a multi-cycle/load unit (port B). B writes are buffered in a small FIFO. The block commits at most one write per cycle with bounded starvation and reports read-after-write hazards for writes it still holds.

---
 rtl/rf_wb_pkg.sv | 18 +
 rtl/rf_wb_fifo.sv | 53 +++++
 rtl/rf_wb_arbiter.sv | 121 ++++++++++++
 tb/tb_rf_wb_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_wb_pkg.sv
// Shared types for the register-file write-port arbiter: request record and grant encoding.
package rf_wb_pkg;

    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DATA_W = 32;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] data;
    } wb_req_t;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_A,
        GNT_B
    } gnt_e;

endpackage

// File: rtl/rf_wb_fifo.sv
// Small synchronous FIFO for port-B write requests; exposes every slot's address and
// occupancy so the arbiter can flag read-after-write hazards on queued writes.
module rf_wb_fifo
    import rf_wb_pkg::*;
#(
    parameter type req_t  = wb_req_t,
    parameter int  ADDR_W = DEF_ADDR_W,
    parameter int  DEPTH  = 2,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = PTR_W + 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  req_t                         push_req,
    input  logic                         pop,
    output req_t                         head,
    output logic [CNT_W-1:0]             count,
    output logic [DEPTH-1:0]             ent_valid,
    output logic [DEPTH-1:0][ADDR_W-1:0] ent_addr
);

    req_t             mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Payload storage needs no reset: a slot is only observed while ent_valid marks it.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_req;
    end

    assign head = mem[rd_ptr];

    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        logic [PTR_W-1:0] off;
        assign off          = PTR_W'(i) - rd_ptr;
        assign ent_valid[i] = CNT_W'(off) < count;
        assign ent_addr[i]  = mem[i].addr;
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the register file's single write port between pipeline writeback (A) and a
// buffered multi-cycle unit (B) with bounded starvation of B and hazard reporting.
module rf_wb_arbiter
    import rf_wb_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int B_DEPTH  = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       a_valid,
    input  logic [ADDR_W-1:0]          a_addr,
    input  logic [DATA_W-1:0]          a_data,
    output logic                       a_ready,
    input  logic                       b_valid,
    input  logic [ADDR_W-1:0]          b_addr,
    input  logic [DATA_W-1:0]          b_data,
    output logic                       b_ready,
    output logic                       rf_we,
    output logic [ADDR_W-1:0]          rf_wa,
    output logic [DATA_W-1:0]          rf_wd,
    input  logic [ADDR_W-1:0]          ra1,
    input  logic [ADDR_W-1:0]          ra2,
    output logic                       haz1,
    output logic                       haz2,
    output logic [$clog2(B_DEPTH):0]   b_count
);

    localparam int CNT_W  = $clog2(B_DEPTH) + 1;
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } req_t;

    req_t                          head;
    req_t                          sel;
    logic [B_DEPTH-1:0]            ent_valid;
    logic [B_DEPTH-1:0][ADDR_W-1:0] ent_addr;
    logic [WAIT_W-1:0]             wait_cnt;
    gnt_e                          gnt;
    logic                          fifo_empty;
    logic                          same_addr;
    logic                          force_b;
    logic                          push;

    rf_wb_fifo #(
        .req_t  (req_t),
        .ADDR_W (ADDR_W),
        .DEPTH  (B_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_req  (req_t'{addr: b_addr, data: b_data}),
        .pop       (gnt == GNT_B),
        .head      (head),
        .count     (b_count),
        .ent_valid (ent_valid),
        .ent_addr  (ent_addr)
    );

    assign fifo_empty = (b_count == '0);
    assign same_addr  = a_valid && (a_addr != '0) && (head.addr == a_addr);
    assign force_b    = (wait_cnt >= WAIT_W'(MAX_WAIT));

    // The queued B write is older, so it must land before a younger A write to the same register.
    always_comb begin
        gnt = GNT_NONE;
        if (fifo_empty) begin
            if (a_valid) gnt = GNT_A;
        end else if (same_addr || force_b) begin
            gnt = GNT_B;
        end else if (a_valid) begin
            gnt = GNT_A;
        end else begin
            gnt = GNT_B;
        end
    end

    assign a_ready = rst_n && !(!fifo_empty && (same_addr || force_b));
    assign b_ready = rst_n && (b_count < CNT_W'(B_DEPTH));
    assign push    = b_valid && b_ready;
    assign sel     = (gnt == GNT_B) ? head : req_t'{addr: a_addr, data: a_data};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we    <= 1'b0;
            rf_wa    <= '0;
            rf_wd    <= '0;
            wait_cnt <= '0;
        end else begin
            rf_we <= 1'b0;
            if (gnt != GNT_NONE) begin
                rf_we <= (sel.addr != '0);
                rf_wa <= sel.addr;
                rf_wd <= sel.data;
            end
            if (fifo_empty || gnt == GNT_B) begin
                wait_cnt <= '0;
            end else if (!force_b) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        haz1 = rf_we && (rf_wa == ra1);
        haz2 = rf_we && (rf_wa == ra2);
        for (int i = 0; i < B_DEPTH; i++) begin
            if (ent_valid[i] && ent_addr[i] == ra1) haz1 = 1'b1;
            if (ent_valid[i] && ent_addr[i] == ra2) haz2 = 1'b1;
        end
        if (!rst_n || ra1 == '0) haz1 = 1'b0;
        if (!rst_n || ra2 == '0) haz2 = 1'b0;
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed scenarios with literal expectations, then randomized
// traffic compared every cycle against a queue-based model of the write-port rules.
module tb_rf_wb_arbiter;
    import rf_wb_pkg::*;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 2;
    localparam int MW    = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          a_valid = 1'b0, b_valid = 1'b0;
    logic [AW-1:0] a_addr = '0, b_addr = '0, ra1 = '0, ra2 = '0;
    logic [DW-1:0] a_data = '0, b_data = '0;
    logic          a_ready, b_ready, rf_we, haz1, haz2;
    logic [AW-1:0] rf_wa;
    logic [DW-1:0] rf_wd;
    logic [1:0]    b_count;

    rf_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .B_DEPTH(DEPTH), .MAX_WAIT(MW)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
        .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
        .ra1(ra1), .ra2(ra2), .haz1(haz1), .haz2(haz2), .b_count(b_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: pending B writes in arrival order, losses of the head, committed write.
    wb_req_t       q[$];
    int            wcnt = 0;
    logic          m_we = 1'b0;
    logic [AW-1:0] m_wa = '0;
    logic [DW-1:0] m_wd = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit m_conflict();
        return q.size() > 0 && a_valid && a_addr != 0 && q[0].addr == a_addr;
    endfunction

    // 0 = nobody, 1 = A, 2 = B head
    function automatic int m_grant();
        if (q.size() == 0) return a_valid ? 1 : 0;
        if (m_conflict() || wcnt >= MW) return 2;
        return a_valid ? 1 : 2;
    endfunction

    function automatic bit m_ardy();
        return !(q.size() > 0 && (m_conflict() || wcnt >= MW));
    endfunction

    function automatic bit m_haz(input logic [AW-1:0] ra);
        if (ra == 0) return 1'b0;
        foreach (q[i]) if (q[i].addr == ra) return 1'b1;
        return m_we && m_wa == ra;
    endfunction

    task automatic model_reset();
        q.delete();
        wcnt = 0;
        m_we = 1'b0;
        m_wa = '0;
        m_wd = '0;
    endtask

    task automatic eval();
        #1;
        chk("a_ready", a_ready, m_ardy());
        chk("b_ready", b_ready, q.size() < DEPTH);
        chk("b_count", b_count, q.size());
        chk("haz1", haz1, m_haz(ra1));
        chk("haz2", haz2, m_haz(ra2));
        chk("rf_we", rf_we, m_we);
        chk("rf_wa", rf_wa, m_wa);
        chk("rf_wd", rf_wd, m_wd);
    endtask

    task automatic clock();
        int      g, sz;
        bit      bpush;
        wb_req_t sel, breq;
        g     = m_grant();
        sz    = q.size();
        sel   = (g == 2) ? q[0] : '{addr: a_addr, data: a_data};
        bpush = b_valid && (sz < DEPTH);
        breq  = '{addr: b_addr, data: b_data};
        @(posedge clk);
        if (g == 2) void'(q.pop_front());
        if (bpush) q.push_back(breq);
        if (g == 2 || sz == 0) wcnt = 0;
        else if (wcnt < MW) wcnt++;
        if (g != 0) begin
            m_we = (sel.addr != 0);
            m_wa = sel.addr;
            m_wd = sel.data;
        end else begin
            m_we = 1'b0;
        end
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bit hold_a, hold_b;

        // Reset values while rst_n is low
        ra1 = 5'd3;
        #12;
        chk("rst_a_ready", a_ready, 0);
        chk("rst_b_ready", b_ready, 0);
        chk("rst_rf_we", rf_we, 0);
        chk("rst_rf_wa", rf_wa, 0);
        chk("rst_rf_wd", rf_wd, 0);
        chk("rst_b_count", b_count, 0);
        chk("rst_haz1", haz1, 0);
        ra1 = '0;
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // A only
        a_valid = 1; a_addr = 3; a_data = 32'hDEADBEEF;
        eval();
        chk("first_a_ready", a_ready, 1);
        chk("first_b_ready", b_ready, 1);
        clock();
        a_valid = 0;
        eval();
        chk("aonly_we", rf_we, 1);
        chk("aonly_wa", rf_wa, 3);
        chk("aonly_wd", rf_wd, 32'hDEADBEEF);
        clock();
        eval();
        chk("aonly_we_drop", rf_we, 0);

        // B backlog under continuous A
        a_valid = 1; a_addr = 1; a_data = 32'h100;
        b_valid = 1; b_addr = 7; b_data = 32'h77;
        eval();
        clock();
        b_valid = 0;
        for (int i = 0; i < MW; i++) begin
            a_data = 32'h200 + i;
            eval();
            chk("backlog_a_wins", a_ready, 1);
            clock();
        end
        eval();
        chk("backlog_forced", a_ready, 0);
        clock();
        eval();
        chk("backlog_we", rf_we, 1);
        chk("backlog_wa", rf_wa, 7);
        chk("backlog_wait_clr", dut.wait_cnt, 0);
        clock();
        a_valid = 0;
        eval();
        clock();

        // Same address: older B write first
        b_valid = 1; b_addr = 9; b_data = 32'd1;
        eval();
        clock();
        b_valid = 0;
        a_valid = 1; a_addr = 9; a_data = 32'd2;
        eval();
        chk("same_a_blocked", a_ready, 0);
        clock();
        eval();
        chk("same_first_wa", rf_wa, 9);
        chk("same_first_wd", rf_wd, 1);
        clock();
        a_valid = 0;
        eval();
        chk("same_second_wd", rf_wd, 2);
        clock();

        // Full FIFO while A saturates
        a_valid = 1; a_addr = 1; a_data = 32'h10;
        b_valid = 1; b_addr = 10; b_data = 32'hA;
        eval();
        clock();
        b_addr = 11; b_data = 32'hB;
        eval();
        clock();
        b_addr = 12; b_data = 32'hC;
        eval();
        chk("full_b_ready", b_ready, 0);
        chk("full_b_count", b_count, 2);
        for (int i = 0; i < 3; i++) begin
            clock();
            eval();
        end
        chk("full_forced", a_ready, 0);
        clock();
        eval();
        chk("full_reopen", b_ready, 1);
        chk("full_after_pop", b_count, 1);
        clock();
        eval();
        chk("full_refill", b_count, 2);
        a_valid = 0; b_valid = 0;
        eval();
        clock();
        b_valid = 1; b_addr = 13; b_data = 32'hD;
        eval();
        clock();
        b_valid = 0;
        eval();
        chk("push_pop_keeps", b_count, 1);
        clock();
        eval();
        clock();
        eval();
        chk("drained", b_count, 0);

        // Address 0 and hazards
        b_valid = 1; b_addr = 0; b_data = 32'h55;
        eval();
        clock();
        b_valid = 0;
        eval();
        chk("addr0_no_haz", haz1, 0);
        clock();
        eval();
        chk("addr0_no_we", rf_we, 0);
        chk("addr0_popped", b_count, 0);
        b_valid = 1; b_addr = 5; b_data = 32'h5; ra1 = 5;
        a_valid = 1; a_addr = 2; a_data = 32'h22;
        eval();
        chk("haz_before_push", haz1, 0);
        clock();
        b_valid = 0;
        eval();
        chk("haz_queued", haz1, 1);
        clock();
        a_valid = 0;
        eval();
        chk("haz_granted", haz1, 1);
        clock();
        eval();
        chk("haz_we", rf_we, 1);
        chk("haz_wa", rf_wa, 5);
        chk("haz_during_we", haz1, 1);
        clock();
        eval();
        chk("haz_cleared", haz1, 0);

        // Asynchronous reset with a full FIFO and a pending write
        ra1 = 6;
        a_valid = 1; a_addr = 4; a_data = 32'h44;
        b_valid = 1; b_addr = 6; b_data = 32'h66;
        eval();
        clock();
        b_addr = 8; b_data = 32'h88;
        eval();
        clock();
        a_valid = 0; b_valid = 0;
        eval();
        chk("pre_rst_count", b_count, 2);
        chk("pre_rst_we", rf_we, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_we", rf_we, 0);
        chk("arst_wa", rf_wa, 0);
        chk("arst_wd", rf_wd, 0);
        chk("arst_count", b_count, 0);
        chk("arst_a_ready", a_ready, 0);
        chk("arst_b_ready", b_ready, 0);
        chk("arst_haz1", haz1, 0);
        model_reset();
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        eval();
        chk("post_rst_count", b_count, 0);
        clock();
        eval();
        chk("no_stale_we", rf_we, 0);

        // Randomized traffic
        hold_a = 0; hold_b = 0;
        for (int c = 0; c < 3000; c++) begin
            if (!hold_a) begin
                a_valid = ($urandom_range(0, 99) < 60);
                a_addr  = AW'($urandom_range(0, 7));
                a_data  = $urandom;
            end
            if (!hold_b) begin
                b_valid = ($urandom_range(0, 99) < 40);
                b_addr  = AW'($urandom_range(0, 7));
                b_data  = $urandom;
            end
            ra1 = AW'($urandom_range(0, 7));
            ra2 = AW'($urandom_range(0, 7));
            eval();
            hold_a = a_valid && !m_ardy();
            hold_b = b_valid && !(q.size() < DEPTH);
            clock();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
